// File: rtl/cell_pos_reader_pkg.sv
// Shared widths, depths and FSM encoding for the cell position reader.
package cell_pos_reader_pkg;

    localparam int POS_DATA_WIDTH    = 96;
    localparam int CELL_ADDR_WIDTH   = 8;
    localparam int CELL_PARTICLE_NUM = 220;
    localparam int POS_FIFO_DEPTH    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_WAIT,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pos_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; rdata is the head entry.
module pos_sync_fifo #(
    parameter int WIDTH = 105,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_idx];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            if (do_pop)
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is left unreset; entries are only ever read after being written.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_idx] <= wdata;
    end

endmodule

// File: rtl/cell_pos_reader.sv
// Reads the particle count at address 0, then streams particles 1..N from a
// 2-cycle-latency RAM to a valid/ready consumer through a credit-limited FIFO.
module cell_pos_reader
    import cell_pos_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = POS_DATA_WIDTH,
    parameter int ADDR_WIDTH   = CELL_ADDR_WIDTH,
    parameter int PARTICLE_NUM = CELL_PARTICLE_NUM,
    parameter int FIFO_DEPTH   = POS_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_last
);

    localparam int FW    = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CRW   = CNT_W + 2;
    localparam logic [ADDR_WIDTH-1:0] N_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] n_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [1:0]            wait_cnt;
    logic                  data_rd;
    logic                  s1_valid;
    logic                  s2_valid;
    logic [ADDR_WIDTH-1:0] s1_pid;
    logic [ADDR_WIDTH-1:0] s2_pid;
    logic [CNT_W-1:0]      fifo_count;
    logic [FW-1:0]         head;
    logic [FW-1:0]         push_word;
    logic [1:0]            inflight;
    logic                  pop;
    logic                  can_issue;
    logic [ADDR_WIDTH-1:0] n_raw;
    logic                  n_over;
    logic [ADDR_WIDTH-1:0] n_count;

    // Outstanding reads include the cycle mem_rden is high, plus the two tracking stages.
    assign inflight  = 2'(data_rd) + 2'(s1_valid) + 2'(s2_valid);
    assign pop       = out_valid & out_ready;
    assign can_issue = (CRW'(fifo_count) + CRW'(inflight) - CRW'(pop)) < CRW'(FIFO_DEPTH);
    assign push_word = {mem_q, s2_pid, (s2_pid == n_reg)};

    assign n_raw   = mem_q[ADDR_WIDTH-1:0];
    assign n_over  = n_raw > N_MAX;
    assign n_count = n_over ? N_MAX : n_raw;

    assign out_valid = (fifo_count != '0);
    assign {out_data, out_pid, out_last} = out_valid ? head : '0;
    assign mem_wren  = 1'b0;
    assign mem_data  = '0;

    pos_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid),
        .wdata (push_word),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_count   <= 1'b0;
            mem_rden    <= 1'b0;
            mem_address <= '0;
            data_rd     <= 1'b0;
            n_reg       <= '0;
            rd_ptr      <= '0;
            wait_cnt    <= '0;
            s1_valid    <= 1'b0;
            s1_pid      <= '0;
            s2_valid    <= 1'b0;
            s2_pid      <= '0;
        end else begin
            done     <= 1'b0;
            mem_rden <= 1'b0;
            data_rd  <= 1'b0;
            s1_valid <= data_rd;
            s1_pid   <= mem_address;
            s2_valid <= s1_valid;
            s2_pid   <= s1_pid;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        err_count   <= 1'b0;
                        mem_rden    <= 1'b1;
                        mem_address <= '0;
                        wait_cnt    <= '0;
                        state       <= ST_CNT_WAIT;
                    end
                end
                ST_CNT_WAIT: begin
                    if (wait_cnt != 2'd2) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else begin
                        n_reg     <= n_count;
                        err_count <= n_over;
                        if (n_count == '0) begin
                            state <= ST_DONE;
                        end else begin
                            // Particle 1 is issued on the same edge the count arrives.
                            mem_rden    <= 1'b1;
                            data_rd     <= 1'b1;
                            mem_address <= ADDR_WIDTH'(1);
                            rd_ptr      <= ADDR_WIDTH'(2);
                            state       <= (n_count == ADDR_WIDTH'(1)) ? ST_DRAIN : ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (can_issue) begin
                        mem_rden    <= 1'b1;
                        data_rd     <= 1'b1;
                        mem_address <= rd_ptr;
                        rd_ptr      <= rd_ptr + 1'b1;
                        if (rd_ptr == n_reg)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (inflight == 2'd0 && fifo_count == CNT_W'(pop))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed bench for cell_pos_reader with a preloaded 2-cycle-latency RAM model.
module tb_cell_pos_reader;

    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        err_count;
    logic [7:0]  mem_address;
    logic        mem_rden;
    logic        mem_wren;
    logic [95:0] mem_data;
    logic [95:0] mem_q;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic [7:0]  out_pid;
    logic        out_last;

    cell_pos_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .mem_address (mem_address),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .mem_data    (mem_data),
        .mem_q       (mem_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_pid     (out_pid),
        .out_last    (out_last)
    );

    always #(PERIOD / 2) clk = ~clk;

    // RAM model: address sampled on the edge ending the rden cycle, data two edges later.
    logic [95:0] ram [256];
    logic [95:0] ram_s1;
    always @(posedge clk) begin
        if (mem_rden)
            ram_s1 <= ram[mem_address];
        mem_q <= ram_s1;
    end

    // Consumer: mode 0 always ready, mode 1 repeats 1,0,0.
    int ready_mode = 0;
    int ready_phase = 0;
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        ready_phase = (ready_phase + 1) % 3;
        out_ready = (ready_mode == 0) ? 1'b1 : (ready_phase == 0);
    end

    // Per-run monitor, restarted when an accepted start is seen.
    logic [95:0] run_data[$];
    int          run_pid[$];
    bit          run_last[$];
    time         run_acc_t[$];
    time         run_start_t;
    time         run_done_t;
    int          run_done_cnt = 0;
    int          run_valid_cycles = 0;
    int          run_max_out = 0;
    int          out_issue = 0;
    int          out_pop = 0;

    always @(negedge clk) begin
        if (rst) begin
            out_issue = 0;
            out_pop   = 0;
        end else begin
            if (start && !busy) begin
                run_start_t = $time;
                run_data.delete();
                run_pid.delete();
                run_last.delete();
                run_acc_t.delete();
                run_done_cnt     = 0;
                run_valid_cycles = 0;
                run_max_out      = 0;
                out_issue        = 0;
                out_pop          = 0;
            end
            if (mem_rden && mem_address != 8'd0)
                out_issue++;
            if (out_issue - out_pop > run_max_out)
                run_max_out = out_issue - out_pop;
            if (out_valid)
                run_valid_cycles++;
            if (out_valid && out_ready) begin
                run_data.push_back(out_data);
                run_pid.push_back(int'(out_pid));
                run_last.push_back(out_last);
                run_acc_t.push_back($time);
                out_pop++;
            end
            if (done) begin
                run_done_cnt++;
                run_done_t = $time;
            end
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] pos_word(input int a);
        return {32'h5000_0000 + 32'(a), 32'h3000_0000 ^ 32'(a * 7), 32'h1000_0000 + 32'(a * 13)};
    endfunction

    task automatic load_ram(input int n);
        for (int a = 0; a < 256; a++)
            ram[a] = pos_word(a);
        ram[0] = 96'(n);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (run_done_cnt == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({tag, "_done_seen"}, 1'(run_done_cnt != 0), 1'b1);
        repeat (20) @(posedge clk);
        #1;
    endtask

    // Counts entries that break pid order, data content or the last flag.
    function automatic int order_errs(input int n);
        int errs;
        errs = 0;
        for (int i = 0; i < run_data.size(); i++) begin
            if (run_pid[i] != i + 1) errs++;
            if (run_data[i] !== pos_word(i + 1)) errs++;
            if (run_last[i] !== (i + 1 == n)) errs++;
        end
        return errs;
    endfunction

    localparam logic [95:0] WORD_A = 96'h0000_0011_0000_0022_0000_0033;
    localparam logic [95:0] WORD_B = 96'hAAAA_0001_BBBB_0002_CCCC_0003;
    localparam logic [95:0] WORD_C = 96'hDEAD_BEEF_0BAD_F00D_1234_5678;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {busy, done, err_count, mem_rden, mem_wren, out_valid, out_last, out_pid, mem_address}, '0);
        check("rst_data", {mem_data, out_data}, '0);
        rst = 1'b0;

        // 1: N=3, consecutive words A,B,C
        load_ram(3);
        ram[1] = WORD_A;
        ram[2] = WORD_B;
        ram[3] = WORD_C;
        ready_mode = 0;
        pulse_start();
        wait_done("t1", 200);
        check("t1_words", run_data.size(), 3);
        if (run_data.size() == 3) begin
            check("t1_data", {run_data[0], run_data[1]}, {WORD_A, WORD_B});
            check("t1_data_c", run_data[2], WORD_C);
            check("t1_pids", {8'(run_pid[0]), 8'(run_pid[1]), 8'(run_pid[2])}, 24'h010203);
            check("t1_last", {run_last[0], run_last[1], run_last[2]}, 3'b001);
            check("t1_consecutive", 64'((run_acc_t[2] - run_acc_t[0]) / PERIOD), 2);
            // Start-sampling edge to first valid: 6 edges.
            check("t1_latency", 64'((run_acc_t[0] - run_start_t) / PERIOD - 1), 6);
            check("t1_done_after_c", 64'((run_done_t - run_acc_t[2]) / PERIOD - 1), 1);
        end
        check("t1_done_pulses", run_done_cnt, 1);
        check("t1_idle", {busy, err_count}, 2'b00);

        // 2: N=0
        load_ram(0);
        pulse_start();
        wait_done("t2", 100);
        check("t2_valid_cycles", run_valid_cycles, 0);
        check("t2_done_latency", 64'((run_done_t - run_start_t) / PERIOD - 1), 4);
        check("t2_done_pulses", run_done_cnt, 1);

        // 3: N=10 under 1,0,0 backpressure
        load_ram(10);
        ready_mode = 1;
        pulse_start();
        wait_done("t3", 500);
        check("t3_words", run_data.size(), 10);
        check("t3_order", order_errs(10), 0);
        check("t3_max_outstanding", run_max_out, 4);
        check("t3_done_pulses", run_done_cnt, 1);

        // 4: count 250 clamps to 219
        load_ram(250);
        ready_mode = 0;
        pulse_start();
        wait_done("t4", 2000);
        check("t4_err_count", err_count, 1'b1);
        check("t4_words", run_data.size(), 219);
        check("t4_order", order_errs(219), 0);
        check("t4_done_pulses", run_done_cnt, 1);

        // 6: second start during STREAM is ignored; err_count cleared by new start
        load_ram(10);
        ready_mode = 1;
        pulse_start();
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t6", 500);
        check("t6_words", run_data.size(), 10);
        check("t6_order", order_errs(10), 0);
        check("t6_done_pulses", run_done_cnt, 1);
        check("t6_err_cleared", err_count, 1'b0);

        // 5: reset mid-STREAM, then a clean run
        load_ram(10);
        ready_mode = 0;
        pulse_start();
        begin
            int k;
            k = 0;
            while (run_data.size() < 4 && k < 200) begin
                @(posedge clk);
                k++;
            end
        end
        check("t5_reached_word4", 1'(run_data.size() >= 4), 1'b1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_outs", {busy, done, err_count, mem_rden, out_valid, out_last, out_pid, mem_address}, '0);
        check("t5_rst_data", out_data, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        pulse_start();
        wait_done("t5", 500);
        check("t5_words", run_data.size(), 10);
        check("t5_order", order_errs(10), 0);
        check("t5_done_pulses", run_done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
